// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, drives a request/ready instruction-memory port, buffers one
// response in a skid register while ID stalls, and squashes in-flight
// responses after a redirect.
// Optional feature macro: IF_MISALIGN_TRAP_EN (adds OUT_FAULT and a terminal
// FAULT state for misaligned redirect targets).
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_SEL,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] OUT_INSTRUCTION,
    output logic [31:0] OUT_PC,
    output logic        OUT_VALID
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        OUT_FAULT
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DISCARD,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;

    logic [31:0] target;
    logic        redirect;
    logic        misaligned;
    logic        fault_pending;
    logic [31:0] pc_plus4;

`ifdef IF_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign misaligned    = (BRANCH_TARGET[1:0] != 2'b00);
    assign fault_pending = fault_q;
    assign OUT_FAULT     = fault_q;
`else
    logic unused_target_bits;
    assign unused_target_bits = ^BRANCH_TARGET[1:0];
    assign misaligned         = 1'b0;
    assign fault_pending      = 1'b0;
`endif

    // Redirect targets are always word aligned; once faulted, redirects are ignored.
    assign target   = {BRANCH_TARGET[31:2], 2'b00};
    assign redirect = PC_SEL && (state_q != ST_FAULT);
    assign pc_plus4 = pc_q + 32'd4;

    assign IMEM_REQ        = imem_req_q;
    assign IMEM_ADDR       = imem_addr_q;
    assign OUT_INSTRUCTION = out_instr_q;
    assign OUT_PC          = out_pc_q;
    assign OUT_VALID       = out_valid_q;

    // State and datapath registers, all cleared asynchronously by RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VECTOR;
            imem_addr_q  <= RESET_VECTOR;
            imem_req_q   <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= 32'h0;
            out_valid_q  <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_addr_q  <= imem_addr_d;
            imem_req_q   <= imem_req_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q      <= fault_d;
`endif
        end
    end

    // Next-state selection: redirect beats stall beats normal flow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = (redirect && misaligned) ? ST_FAULT : ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    if (IMEM_READY) state_d = misaligned ? ST_FAULT : ST_FETCH;
                    else            state_d = ST_DISCARD;
                end else if (IMEM_READY && STALL && out_valid_q) begin
                    state_d = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (IMEM_READY) begin
                    state_d = (fault_pending || (redirect && misaligned)) ? ST_FAULT : ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect)    state_d = misaligned ? ST_FAULT : ST_FETCH;
                else if (!STALL) state_d = ST_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    // Datapath updates: PC, fetch address, presented instruction and skid buffer.
    always_comb begin
        pc_d         = pc_q;
        imem_addr_d  = imem_addr_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_valid_d  = out_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
`ifdef IF_MISALIGN_TRAP_EN
        fault_d      = fault_q;
`endif

        if (!STALL) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
        end

        case (state_q)
            ST_IDLE: begin
                imem_addr_d = pc_q;
                if (redirect) begin
                    pc_d        = target;
                    imem_addr_d = target;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    pc_d = target;
                    if (IMEM_READY) imem_addr_d = target;
                end else if (IMEM_READY) begin
                    pc_d = pc_plus4;
                    if (STALL && out_valid_q) begin
                        skid_instr_d = IMEM_RDATA;
                        skid_pc_d    = pc_q;
                        skid_valid_d = 1'b1;
                    end else begin
                        out_instr_d = IMEM_RDATA;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        imem_addr_d = pc_plus4;
                    end
                end
            end
            ST_DISCARD: begin
                if (redirect) pc_d = target;
                if (IMEM_READY) imem_addr_d = redirect ? target : pc_q;
            end
            ST_HOLD: begin
                if (redirect) begin
                    skid_valid_d = 1'b0;
                    pc_d         = target;
                    imem_addr_d  = target;
                end else if (!STALL) begin
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                    imem_addr_d  = pc_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_instr_d = NOP_INSTR;
            end
        endcase

        if (redirect) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
            if (misaligned) fault_d = 1'b1;
`endif
        end
    end

    // Memory request is asserted whenever the next state owns an outstanding fetch.
    always_comb begin
        imem_req_d = (state_d == ST_FETCH) || (state_d == ST_DISCARD);
    end

endmodule
